// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// A queue entry carries the fetched word, its PC and the bus-error flag.
package fetch_pkg;

    localparam logic [31:0] BOOT_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int          INST_W              = 32;
    localparam int          PC_W                = 32;

    typedef struct packed {
        logic              fault;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are word aligned; redirect targets drop their low two bits.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Decode-side and icache-side signals of the fetch unit, bundled as one interface.
// The master modport is the fetch unit's view; slave is the surrounding logic.
interface fetch_if;
    import fetch_pkg::*;

    logic              fetch_accept_i;
    logic              branch_request_i;
    logic [PC_W-1:0]   branch_pc_i;
    logic              fetch_invalidate_i;
    logic              icache_accept_i;
    logic              icache_valid_i;
    logic              icache_error_i;
    logic [INST_W-1:0] icache_inst_i;

    logic              fetch_valid_o;
    logic [INST_W-1:0] fetch_instr_o;
    logic [PC_W-1:0]   fetch_pc_o;
    logic              fetch_fault_o;
    logic              icache_rd_o;
    logic              icache_flush_o;
    logic              icache_invalidate_o;
    logic [PC_W-1:0]   icache_pc_o;

    modport master (
        input  fetch_accept_i, branch_request_i, branch_pc_i, fetch_invalidate_i,
               icache_accept_i, icache_valid_i, icache_error_i, icache_inst_i,
        output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o,
               icache_rd_o, icache_flush_o, icache_invalidate_o, icache_pc_o
    );

    modport slave (
        output fetch_accept_i, branch_request_i, branch_pc_i, fetch_invalidate_i,
               icache_accept_i, icache_valid_i, icache_error_i, icache_inst_i,
        input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_o,
               icache_rd_o, icache_flush_o, icache_invalidate_o, icache_pc_o
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO between the icache response and decode.
// Push and pop may coincide at any fill level; flush empties it immediately.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W = ENTRY_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // When full, a push only lands if the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues one icache read at a time,
// queues responses toward decode, discards stale responses after redirects and sequences fence.i flushes.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_VECTOR = BOOT_VECTOR_DEFAULT
) (
    input logic   clk_i,
    input logic   rst_i,
    fetch_if.master bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] req_pc_q;
    logic            outstanding_q;
    logic            discard_q;
    logic            flush_pending_q;

    logic [1:0]      count;
    logic            head_valid;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            pop;
    logic            resp;
    logic            push;
    logic            issue;
    logic            flush_hs;
    logic [2:0]      credit;

    assign pop    = head_valid && bus.fetch_accept_i;
    assign resp   = bus.icache_valid_i && outstanding_q;
    assign push   = resp && !discard_q && !bus.branch_request_i;
    // Slots already claimed once this cycle's pop is taken into account.
    assign credit = {1'b0, count} + {2'b00, outstanding_q} - {2'b00, pop};

    assign bus.icache_rd_o = !rst_i && !bus.branch_request_i && !flush_pending_q &&
                             (!outstanding_q || bus.icache_valid_i) && (credit < 3'd2);
    assign issue = bus.icache_rd_o && bus.icache_accept_i;

    assign bus.icache_flush_o = !rst_i && flush_pending_q && !outstanding_q &&
                                !bus.branch_request_i;
    assign flush_hs = bus.icache_flush_o && bus.icache_accept_i;

    assign bus.icache_pc_o         = pc_q;
    assign bus.icache_invalidate_o = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q            <= BOOT_VECTOR;
            outstanding_q   <= 1'b0;
            discard_q       <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            if (bus.branch_request_i)  pc_q <= align_pc(bus.branch_pc_i);
            else if (issue)            pc_q <= pc_q + 32'd4;

            if (issue)                 outstanding_q <= 1'b1;
            else if (resp)             outstanding_q <= 1'b0;

            // A read still in flight across a redirect belongs to the old path.
            if (bus.branch_request_i && outstanding_q && !bus.icache_valid_i)
                discard_q <= 1'b1;
            else if (resp)
                discard_q <= 1'b0;

            if (bus.fetch_invalidate_i) flush_pending_q <= 1'b1;
            else if (flush_hs)          flush_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) req_pc_q <= pc_q;
    end

    assign push_entry = '{fault: bus.icache_error_i, pc: req_pc_q, inst: bus.icache_inst_i};

    fetch_skid_fifo #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.branch_request_i),
        .data_i  (push_entry),
        .valid_o (head_valid),
        .data_o  (head),
        .count_o (count)
    );

    // Storage is not reset, so the head is masked while the queue is empty.
    assign bus.fetch_valid_o = head_valid;
    assign bus.fetch_instr_o = head_valid ? head.inst  : '0;
    assign bus.fetch_pc_o    = head_valid ? head.pc    : '0;
    assign bus.fetch_fault_o = head_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for streaming, stall,
// error, redirect and flush, then hand-written redirect and PC-wrap sequences.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.BOOT_VECTOR(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        acc, br;
        logic [31:0] bpc;
        logic        inv, ica, iv, ierr;
        logic [31:0] inst;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic        e_fault, e_rd, e_flush;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [31:0] iw(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    function automatic vec_t mk(input logic acc, br, input logic [31:0] bpc,
                                input logic inv, ica, iv, ierr, input logic [31:0] inst,
                                input logic ev, input logic [31:0] epc, einstr,
                                input logic ef, erd, efl, input logic [31:0] eipc);
        vec_t v;
        v.acc = acc; v.br = br; v.bpc = bpc; v.inv = inv; v.ica = ica;
        v.iv = iv; v.ierr = ierr; v.inst = inst;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = einstr; v.e_fault = ef;
        v.e_rd = erd; v.e_flush = efl; v.e_ipc = eipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic acc, br, input logic [31:0] bpc,
                          input logic inv, ica, iv, ierr, input logic [31:0] inst);
        bus.fetch_accept_i     = acc;
        bus.branch_request_i   = br;
        bus.branch_pc_i        = bpc;
        bus.fetch_invalidate_i = inv;
        bus.icache_accept_i    = ica;
        bus.icache_valid_i     = iv;
        bus.icache_error_i     = ierr;
        bus.icache_inst_i      = inst;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc, einstr,
                           input logic ef, erd, efl, input logic [31:0] eipc);
        chk({tag, " valid"}, 32'(bus.fetch_valid_o), 32'(ev));
        chk({tag, " pc"}, bus.fetch_pc_o, epc);
        chk({tag, " instr"}, bus.fetch_instr_o, einstr);
        chk({tag, " fault"}, 32'(bus.fetch_fault_o), 32'(ef));
        chk({tag, " rd"}, 32'(bus.icache_rd_o), 32'(erd));
        chk({tag, " flush"}, 32'(bus.icache_flush_o), 32'(efl));
        chk({tag, " icache_pc"}, bus.icache_pc_o, eipc);
        chk({tag, " inval"}, 32'(bus.icache_invalidate_o), 32'd0);
    endtask

    // The queue must never be pushed while full without a pop.
    always @(posedge clk) begin
        if (!rst && dut.u_fifo.count_o == 2'd2 && dut.u_fifo.push_i &&
            !dut.u_fifo.pop_i && !dut.u_fifo.flush_i) begin
            n_miss++;
            $display("FAIL overflow: push into full queue at %0t", $time);
        end
    end

    initial begin
        // Streaming hits, decode stall, error entry, redirect over a miss, fence.i over a miss.
        vecs[0]  = mk(1,0,0,0,1,0,0,0,         0,0,0,0,1,0,32'h0);
        vecs[1]  = mk(1,0,0,0,1,1,0,iw(0),     0,0,0,0,1,0,32'h4);
        vecs[2]  = mk(1,0,0,0,1,1,0,iw(1),     1,32'h0,iw(0),0,1,0,32'h8);
        vecs[3]  = mk(1,0,0,0,1,1,0,iw(2),     1,32'h4,iw(1),0,1,0,32'hC);
        vecs[4]  = mk(0,0,0,0,1,1,0,iw(3),     1,32'h8,iw(2),0,0,0,32'h10);
        vecs[5]  = mk(0,0,0,0,1,0,0,0,         1,32'h8,iw(2),0,0,0,32'h10);
        vecs[6]  = mk(0,0,0,0,1,0,0,0,         1,32'h8,iw(2),0,0,0,32'h10);
        vecs[7]  = mk(1,0,0,0,1,0,0,0,         1,32'h8,iw(2),0,1,0,32'h10);
        vecs[8]  = mk(1,0,0,0,1,1,0,iw(4),     1,32'hC,iw(3),0,1,0,32'h14);
        vecs[9]  = mk(1,0,0,0,1,1,1,iw(5),     1,32'h10,iw(4),0,1,0,32'h18);
        vecs[10] = mk(1,0,0,0,1,1,0,iw(6),     1,32'h14,iw(5),1,1,0,32'h1C);
        vecs[11] = mk(1,0,0,0,1,0,0,0,         1,32'h18,iw(6),0,0,0,32'h20);
        vecs[12] = mk(1,1,32'h1002,0,1,0,0,0,  0,0,0,0,0,0,32'h20);
        vecs[13] = mk(1,0,0,0,1,0,0,0,         0,0,0,0,0,0,32'h1000);
        vecs[14] = mk(1,0,0,0,1,1,0,iw(7),     0,0,0,0,1,0,32'h1000);
        vecs[15] = mk(1,0,0,0,1,1,0,iw(8),     0,0,0,0,1,0,32'h1004);
        vecs[16] = mk(1,0,0,0,1,0,0,0,         1,32'h1000,iw(8),0,0,0,32'h1008);
        vecs[17] = mk(1,0,0,1,1,0,0,0,         0,0,0,0,0,0,32'h1008);
        vecs[18] = mk(1,0,0,0,1,0,0,0,         0,0,0,0,0,0,32'h1008);
        vecs[19] = mk(1,0,0,0,1,1,0,iw(9),     0,0,0,0,0,0,32'h1008);
        vecs[20] = mk(1,0,0,0,0,0,0,0,         1,32'h1004,iw(9),0,0,1,32'h1008);
        vecs[21] = mk(1,0,0,0,1,0,0,0,         0,0,0,0,0,1,32'h1008);
        vecs[22] = mk(1,0,0,0,1,0,0,0,         0,0,0,0,1,0,32'h1008);
        vecs[23] = mk(1,0,0,0,1,1,0,iw(10),    0,0,0,0,1,0,32'h100C);
        vecs[24] = mk(1,0,0,0,1,0,0,0,         1,32'h1008,iw(10),0,0,0,32'h1010);

        rst = 1'b1;
        set_in(0,0,0,0,0,0,0,0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            set_in(vecs[i].acc, vecs[i].br, vecs[i].bpc, vecs[i].inv, vecs[i].ica,
                   vecs[i].iv, vecs[i].ierr, vecs[i].inst);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_fault, vecs[i].e_rd, vecs[i].e_flush, vecs[i].e_ipc);
            @(negedge clk);
        end

        // Redirect coinciding with a response and a pop, then redirect with a full queue.
        rst = 1'b1;
        set_in(0,0,0,0,0,0,0,0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0,0,0,0,1,0,0,0);            #1; chk_out("h0", 0,0,0,0,1,0,32'h0);    @(negedge clk);
        set_in(0,0,0,0,1,1,0,32'hB0);       #1; chk_out("h1", 0,0,0,0,1,0,32'h4);    @(negedge clk);
        set_in(1,1,32'h2000,0,1,1,0,32'hB1);#1; chk_out("h2", 1,32'h0,32'hB0,0,0,0,32'h8); @(negedge clk);
        set_in(1,0,0,0,1,0,0,0);            #1; chk_out("h3", 0,0,0,0,1,0,32'h2000);
        chk("h3 discard", 32'(dut.discard_q), 32'd0);
        @(negedge clk);
        set_in(0,0,0,0,1,1,0,32'hB2);       #1; chk_out("h4", 0,0,0,0,1,0,32'h2004); @(negedge clk);
        set_in(0,0,0,0,1,1,0,32'hB3);       #1; chk_out("h5", 1,32'h2000,32'hB2,0,0,0,32'h2008); @(negedge clk);
        set_in(1,1,32'h3001,0,1,0,0,0);     #1; chk_out("h6", 1,32'h2000,32'hB2,0,0,0,32'h2008);
        chk("h6 count", 32'(dut.u_fifo.count_o), 32'd2);
        @(negedge clk);
        set_in(1,0,0,0,1,0,0,0);            #1; chk_out("h7", 0,0,0,0,1,0,32'h3000); @(negedge clk);

        // Redirect to the last word of the address space, then wrap to zero.
        set_in(1,1,32'hFFFF_FFFF,0,1,1,0,32'hC0); #1; chk_out("h8", 0,0,0,0,0,0,32'h3004); @(negedge clk);
        set_in(1,0,0,0,1,0,0,0);            #1; chk_out("h9", 0,0,0,0,1,0,32'hFFFF_FFFC); @(negedge clk);
        set_in(1,0,0,0,1,1,0,32'hC1);       #1; chk_out("h10", 0,0,0,0,1,0,32'h0);   @(negedge clk);
        set_in(1,0,0,0,0,0,0,0);            #1; chk_out("h11", 1,32'hFFFF_FFFC,32'hC1,0,0,0,32'h4);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
